// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control for the single-cycle MIPS core; next-PC select, stall, halt.
// Latency: one clock from sampled redirect to pc_out; stall holds PC and counter. Optional PC_ALIGN_TRAP_EN.
// Backpressure: stall freezes PC, retired counter and state; redirects are dropped while stalled.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_DEPTH  = 256,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int          COUNT_W     = 16
`ifdef PC_ALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0380
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        instr_in,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic               jr,
    input  logic [31:0]        jr_target,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr_out,
    output logic               instr_valid,
    output logic               halted,
    output logic [COUNT_W-1:0] retired_count,
    output logic               trap,
    output logic [31:0]        epc
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // 33 bits so a program window ending exactly at 2^32 still compares correctly.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IMEM_DEPTH) << 2);

    state_t             state_q;
    logic [31:0]        pc_q;
    logic [COUNT_W-1:0] count_q;
    logic               halted_q;
    logic [31:0]        target;
    logic [31:0]        next_pc;
    logic               misaligned;
    logic               past_end;
    logic               is_halt_word;
    logic               active;

    assign pc_out        = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign halted        = halted_q;
    assign retired_count = count_q;

    assign is_halt_word = (instr_in == HALT_WORD);
    assign active       = (state_q == S_RUN) && !stall;
    assign instr_valid  = active && !is_halt_word;
    assign instr_out    = instr_valid ? instr_in : 32'h0;

    always_comb begin
        target = pc_plus4;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            target = pc_plus4 + (branch_offset << 2);
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

`ifdef PC_ALIGN_TRAP_EN
    assign next_pc = misaligned ? TRAP_VECTOR : target;
`else
    assign next_pc = target & 32'hFFFF_FFFC;
`endif

    assign past_end = ({1'b0, next_pc} >= PC_LIMIT);

`ifdef PC_ALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] epc_q;

    assign trap = trap_q;
    assign epc  = epc_q;
`else
    assign trap = 1'b0;
    assign epc  = 32'h0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            halted_q <= 1'b0;
`ifdef PC_ALIGN_TRAP_EN
            trap_q   <= 1'b0;
            epc_q    <= 32'h0;
`endif
        end else begin
`ifdef PC_ALIGN_TRAP_EN
            trap_q <= 1'b0;
`endif
            case (state_q)
                S_BOOT: state_q <= S_RUN;
                S_RUN: begin
                    if (active) begin
                        if (is_halt_word) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            if (count_q != '1) begin
                                count_q <= count_q + 1'b1;
                            end
                            // Running off the end commits this word but keeps PC on it.
                            if (past_end) begin
                                state_q  <= S_HALT;
                                halted_q <= 1'b1;
                            end else begin
                                pc_q <= next_pc;
`ifdef PC_ALIGN_TRAP_EN
                                if (misaligned) begin
                                    trap_q <= 1'b1;
                                    epc_q  <= pc_q;
                                end
`endif
                            end
                        end
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a cycle-level reference model and literal checkpoints.
module tb_pc_fetch_unit;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'h0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic [15:0] retired_count;
    logic        trap;
    logic [31:0] epc;

    logic [31:0] imem [0:255];
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    assign instr_in = imem[pc_out[9:2]];

    pc_fetch_unit dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_out(instr_out),
        .instr_valid(instr_valid), .halted(halted), .retired_count(retired_count),
        .trap(trap), .epc(epc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic        started;
        logic        halt;
        logic [15:0] cnt;
        logic        trap;
        logic [31:0] epc;
    } mst_t;

    mst_t m;

    function automatic mst_t model_step(input mst_t s);
        mst_t        n;
        logic [31:0] w;
        logic [31:0] p4;
        logic [31:0] t;
        logic        tr;
        n      = s;
        n.trap = 1'b0;
        if (!s.started) begin
            n.started = 1'b1;
            return n;
        end
        if (s.halt || stall) return n;
        w = imem[s.pc[9:2]];
        if (w == HALT_W) begin
            n.halt = 1'b1;
            return n;
        end
        if (s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
        p4 = s.pc + 32'd4;
        if (jr) t = jr_target;
        else if (jump) t = {p4[31:28], jump_target, 2'b00};
        else if (branch_taken) t = p4 + branch_offset * 32'd4;
        else t = p4;
        tr = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
        if (t % 4 != 0) begin
            tr = 1'b1;
            t  = 32'h380;
        end
`else
        t = t - (t % 4);
`endif
        if (t >= 32'h400) begin
            n.halt = 1'b1;
        end else begin
            n.pc   = t;
            n.trap = tr;
            if (tr) n.epc = s.pc;
        end
        return n;
    endfunction

    function automatic logic exp_valid();
        return m.started && !m.halt && !stall && (imem[m.pc[9:2]] != HALT_W);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_step(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("m_pc", pc_out, m.pc);
            chk("m_pc4", pc_plus4, m.pc + 32'd4);
            chk("m_valid", {31'h0, instr_valid}, {31'h0, exp_valid()});
            chk("m_instr", instr_out, exp_valid() ? imem[m.pc[9:2]] : 32'h0);
            chk("m_halted", {31'h0, halted}, {31'h0, m.halt});
            chk("m_count", {16'h0, retired_count}, {16'h0, m.cnt});
            chk("m_trap", {31'h0, trap}, {31'h0, m.trap});
            chk("m_epc", epc, m.epc);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h2000_0000 + i;
        imem[5] = HALT_W;
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        step();
        step();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_count", {16'h0, retired_count}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);

        reset = 1'b1;
        #1;
        chk("boot_valid", {31'h0, instr_valid}, 32'h0);
        chk("boot_pc", pc_out, 32'h0);
        step();
        chk("run_valid", {31'h0, instr_valid}, 32'h1);
        chk("run_instr", instr_out, 32'h2000_0000);
        step();
        chk("seq_pc4", pc_out, 32'h4);
        step();
        step();
        chk("seq_pcC", pc_out, 32'hC);
        chk("seq_count3", {16'h0, retired_count}, 32'd3);

        step();
        chk("pre_br_pc", pc_out, 32'h10);
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0; branch_offset = 32'h0;
        chk("branch_back", pc_out, 32'hC);
        chk("branch_count", {16'h0, retired_count}, 32'd5);

        jr = 1'b1; jr_target = 32'h20;
        step();
        jr = 1'b0;
        chk("jr_to20", pc_out, 32'h20);
        jr = 1'b1; jr_target = 32'h40; jump = 1'b1; jump_target = 26'h10;
        branch_taken = 1'b1; branch_offset = 32'h5;
        step();
        jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        chk("jr_wins", pc_out, 32'h40);
        chk("prio_count", {16'h0, retired_count}, 32'd7);

        jr = 1'b1; jr_target = 32'h8;
        step();
        jr = 1'b0;
        stall = 1'b1; jump = 1'b1; jump_target = 26'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_out, 32'h8);
            chk("stall_count", {16'h0, retired_count}, 32'd8);
            chk("stall_valid", {31'h0, instr_valid}, 32'h0);
        end
        stall = 1'b0; jump = 1'b0;

        step();
        step();
        step();
        chk("hw_pc", pc_out, 32'h14);
        chk("hw_valid", {31'h0, instr_valid}, 32'h0);
        chk("hw_instr", instr_out, 32'h0);
        step();
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_pc", pc_out, 32'h14);
        chk("halt_count", {16'h0, retired_count}, 32'd11);
        jr = 1'b1; jr_target = 32'h0;
        step();
        chk("halt_sticky", pc_out, 32'h14);
        reset = 1'b0;
        #1;
        jr = 1'b0;
        chk("mid_rst_pc", pc_out, 32'h0);
        chk("mid_rst_halted", {31'h0, halted}, 32'h0);
        chk("mid_rst_count", {16'h0, retired_count}, 32'h0);
        step();
        reset = 1'b1;

        step();
        step();
        chk("re_pc4", pc_out, 32'h4);
        jr = 1'b1; jr_target = 32'h41;
        step();
        jr = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
        chk("mis_pc", pc_out, 32'h380);
        chk("mis_trap", {31'h0, trap}, 32'h1);
        chk("mis_epc", epc, 32'h4);
`else
        chk("mis_pc", pc_out, 32'h40);
        chk("mis_trap", {31'h0, trap}, 32'h0);
        chk("mis_epc", epc, 32'h0);
`endif
        step();
        chk("trap_pulse", {31'h0, trap}, 32'h0);

        jr = 1'b1; jr_target = 32'h3FC;
        step();
        jr = 1'b0;
        chk("end_pc", pc_out, 32'h3FC);
        step();
        chk("end_halt", {31'h0, halted}, 32'h1);
        chk("end_pc_hold", pc_out, 32'h3FC);
        chk("end_count", {16'h0, retired_count}, 32'd5);
        step();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
